// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow-control unit: load-use bubble, taken-branch flush, memory-busy freeze
// and EX-stage operand forwarding selects for a short in-order pipeline.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] R1_addr_RR,
    input  logic [4:0] R2_addr_RR,
    input  logic       R1_used_RR,
    input  logic       R2_used_RR,
    input  logic [4:0] R1_addr_EX,
    input  logic [4:0] R2_addr_EX,
    input  logic [4:0] R3_addr_EX,
    input  logic [1:0] R3_dcntrl_EX,
    input  logic       branch_taken_EX,
    input  logic       mem_busy,
    output logic       enable_PC,
    output logic       enable_IF,
    output logic       enable_RR,
    output logic       enable_MEM,
    output logic       clear_IF,
    output logic       clear_RR,
    output logic [1:0] fwd_sel1_EX,
    output logic [1:0] fwd_sel2_EX
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        FLUSH   = 2'b10
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t     state_r, state_next_s;
    logic [2:0] count_r, count_next_s;
    logic [4:0] dest_mem_r, dest_wb_r;
    logic [1:0] dcntrl_mem_r, dcntrl_wb_r;
    logic       load_use_s;
    logic       en_pc_s, en_if_s, en_rr_s, en_mem_s, clr_if_s, clr_rr_s;
    logic [1:0] fwd1_s, fwd2_s;

    // MEM stage only forwards results that exist there (ALU or PC+4), never load data.
    function automatic logic mem_has_result(input logic [1:0] dc);
        return (dc == 2'b01) || (dc == 2'b11);
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] d_mem,
        input logic [1:0] dc_mem,
        input logic [4:0] d_wb,
        input logic [1:0] dc_wb
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != 5'd0) begin
            if ((src == d_mem) && mem_has_result(dc_mem)) begin
                sel = 2'b01;
            end else if ((src == d_wb) && (dc_wb != 2'b00)) begin
                sel = 2'b10;
            end else begin
                sel = 2'b00;
            end
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Load in EX whose destination is read by the RR instruction.
    always_comb begin
        load_use_s = (R3_dcntrl_EX == 2'b10) && (R3_addr_EX != 5'd0) &&
                     ((R1_used_RR && (R1_addr_RR == R3_addr_EX)) ||
                      (R2_used_RR && (R2_addr_RR == R3_addr_EX)));
    end

    // Next-state and raw enable/clear decode, mem_busy overriding everything.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        en_pc_s      = 1'b1;
        en_if_s      = 1'b1;
        en_rr_s      = 1'b1;
        en_mem_s     = 1'b1;
        clr_if_s     = 1'b0;
        clr_rr_s     = 1'b0;
        if (mem_busy) begin
            en_pc_s  = 1'b0;
            en_if_s  = 1'b0;
            en_rr_s  = 1'b0;
            en_mem_s = 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (branch_taken_EX) begin
                        clr_if_s = 1'b1;
                        clr_rr_s = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_next_s = FLUSH;
                            count_next_s = FLUSH_INIT;
                        end else begin
                            state_next_s = RUN;
                            count_next_s = 3'd0;
                        end
                    end else if (load_use_s) begin
                        en_pc_s      = 1'b0;
                        en_if_s      = 1'b0;
                        clr_rr_s     = 1'b1;
                        state_next_s = LDSTALL;
                    end else begin
                        state_next_s = RUN;
                    end
                end
                LDSTALL: begin
                    state_next_s = RUN;
                end
                FLUSH: begin
                    clr_if_s = 1'b1;
                    clr_rr_s = 1'b1;
                    if (count_r <= 3'd1) begin
                        state_next_s = RUN;
                        count_next_s = 3'd0;
                    end else begin
                        count_next_s = count_r - 3'd1;
                    end
                end
                default: begin
                    state_next_s = RUN;
                    count_next_s = 3'd0;
                end
            endcase
        end
    end

    // FSM state and flush counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= RUN;
            count_r <= 3'd0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Destination trackers advance with the EX->MEM register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_mem_r   <= 5'd0;
            dcntrl_mem_r <= 2'b00;
            dest_wb_r    <= 5'd0;
            dcntrl_wb_r  <= 2'b00;
        end else if (en_mem_s) begin
            dest_mem_r   <= R3_addr_EX;
            dcntrl_mem_r <= R3_dcntrl_EX;
            dest_wb_r    <= dest_mem_r;
            dcntrl_wb_r  <= dcntrl_mem_r;
        end else begin
            dest_mem_r   <= dest_mem_r;
            dcntrl_mem_r <= dcntrl_mem_r;
            dest_wb_r    <= dest_wb_r;
            dcntrl_wb_r  <= dcntrl_wb_r;
        end
    end

    // Forwarding selects for both EX operands.
    always_comb begin
        fwd1_s = fwd_sel(R1_addr_EX, dest_mem_r, dcntrl_mem_r, dest_wb_r, dcntrl_wb_r);
        fwd2_s = fwd_sel(R2_addr_EX, dest_mem_r, dcntrl_mem_r, dest_wb_r, dcntrl_wb_r);
    end

    // While reset is asserted the outputs show the idle pipe regardless of inputs.
    always_comb begin
        if (!reset) begin
            enable_PC   = 1'b1;
            enable_IF   = 1'b1;
            enable_RR   = 1'b1;
            enable_MEM  = 1'b1;
            clear_IF    = 1'b0;
            clear_RR    = 1'b0;
            fwd_sel1_EX = 2'b00;
            fwd_sel2_EX = 2'b00;
        end else begin
            enable_PC   = en_pc_s;
            enable_IF   = en_if_s;
            enable_RR   = en_rr_s;
            enable_MEM  = en_mem_s;
            clear_IF    = clr_if_s;
            clear_RR    = clr_rr_s;
            fwd_sel1_EX = fwd1_s;
            fwd_sel2_EX = fwd2_s;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a cycle-level reference model checked every negative
// clock edge, plus literal checks of the directed scenarios.
module tb_pipe_hazard_ctrl;

    localparam int FC = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] R1_addr_RR, R2_addr_RR, R1_addr_EX, R2_addr_EX, R3_addr_EX;
    logic       R1_used_RR, R2_used_RR, branch_taken_EX, mem_busy;
    logic [1:0] R3_dcntrl_EX;
    logic       enable_PC, enable_IF, enable_RR, enable_MEM, clear_IF, clear_RR;
    logic [1:0] fwd_sel1_EX, fwd_sel2_EX;

    int vectors = 0;
    int miscompares = 0;

    // model state: remaining flush cycles, pending stall cycle, destination history (newest first)
    int         flush_left;
    int         stall_left;
    logic [6:0] hist [$];

    pipe_hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .R1_addr_RR(R1_addr_RR), .R2_addr_RR(R2_addr_RR),
        .R1_used_RR(R1_used_RR), .R2_used_RR(R2_used_RR),
        .R1_addr_EX(R1_addr_EX), .R2_addr_EX(R2_addr_EX),
        .R3_addr_EX(R3_addr_EX), .R3_dcntrl_EX(R3_dcntrl_EX),
        .branch_taken_EX(branch_taken_EX), .mem_busy(mem_busy),
        .enable_PC(enable_PC), .enable_IF(enable_IF), .enable_RR(enable_RR),
        .enable_MEM(enable_MEM), .clear_IF(clear_IF), .clear_RR(clear_RR),
        .fwd_sel1_EX(fwd_sel1_EX), .fwd_sel2_EX(fwd_sel2_EX)
    );

    always #5 clk = ~clk;

    function automatic bit model_load_use();
        return (R3_dcntrl_EX == 2'b10) && (R3_addr_EX != 5'd0) &&
               ((R1_used_RR && R1_addr_RR == R3_addr_EX) ||
                (R2_used_RR && R2_addr_RR == R3_addr_EX));
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        logic [4:0] md, wd;
        logic [1:0] mc, wc;
        {md, mc} = hist[0];
        {wd, wc} = hist[1];
        if (src == 5'd0) return 2'b00;
        if (src == md && (mc == 2'b01 || mc == 2'b11)) return 2'b01;
        if (src == wd && wc != 2'b00) return 2'b10;
        return 2'b00;
    endfunction

    // packed {en_PC, en_IF, en_RR, en_MEM, clr_IF, clr_RR, fwd1, fwd2}
    function automatic logic [9:0] model_out();
        logic [5:0] ctl;
        if (!reset) return 10'b1111_00_00_00;
        if (mem_busy)                 ctl = 6'b0000_00;
        else if (flush_left > 0)      ctl = 6'b1111_11;
        else if (stall_left > 0)      ctl = 6'b1111_00;
        else if (branch_taken_EX)     ctl = 6'b1111_11;
        else if (model_load_use())    ctl = 6'b0011_01;
        else                          ctl = 6'b1111_00;
        return {ctl, model_fwd(R1_addr_EX), model_fwd(R2_addr_EX)};
    endfunction

    // Reference model advances on each clock edge the pipe is out of reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_left = 0;
            stall_left = 0;
            hist = '{7'd0, 7'd0};
        end else if (!mem_busy) begin
            if (flush_left > 0)           flush_left = flush_left - 1;
            else if (stall_left > 0)      stall_left = 0;
            else if (branch_taken_EX)     flush_left = FC - 1;
            else if (model_load_use())    stall_left = 1;
            hist.push_front({R3_addr_EX, R3_dcntrl_EX});
            hist = hist[0:1];
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [9:0] act, exp;
        act = {enable_PC, enable_IF, enable_RR, enable_MEM, clear_IF, clear_RR,
               fwd_sel1_EX, fwd_sel2_EX};
        exp = model_out();
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL model t=%0t outputs got %b expected %b", $time, act, exp);
        end
    end

    task automatic lit(input string name, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    // drive one cycle of inputs just after the rising edge, return mid-cycle after the compare
    task automatic apply(input logic [4:0] r1rr, input logic [4:0] r2rr,
                         input logic u1, input logic u2,
                         input logic [4:0] r1ex, input logic [4:0] r2ex,
                         input logic [4:0] r3ex, input logic [1:0] dc,
                         input logic br, input logic busy);
        @(posedge clk);
        #1;
        R1_addr_RR = r1rr; R2_addr_RR = r2rr; R1_used_RR = u1; R2_used_RR = u2;
        R1_addr_EX = r1ex; R2_addr_EX = r2ex; R3_addr_EX = r3ex; R3_dcntrl_EX = dc;
        branch_taken_EX = br; mem_busy = busy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        R1_addr_RR = 5'd0; R2_addr_RR = 5'd0; R1_used_RR = 1'b0; R2_used_RR = 1'b0;
        R1_addr_EX = 5'd0; R2_addr_EX = 5'd0; R3_addr_EX = 5'd0; R3_dcntrl_EX = 2'b00;
        branch_taken_EX = 1'b0; mem_busy = 1'b0;
        hist = '{7'd0, 7'd0};
        flush_left = 0;
        stall_left = 0;

        // reset state
        apply(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("reset_enables", {enable_PC, enable_MEM}, 2'b11);
        lit("reset_clears", {clear_IF, clear_RR}, 2'b00);
        @(posedge clk);
        #1 reset = 1'b1;

        // dependent ALU pair: ADD r5 then SUB r5
        apply(5'd5, 5'd1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 2'b01, 1'b0, 1'b0);
        lit("alu_no_stall", {enable_PC, enable_IF}, 2'b11);
        apply(5'd2, 5'd3, 1'b1, 1'b1, 5'd5, 5'd2, 5'd6, 2'b01, 1'b0, 1'b0);
        lit("alu_fwd_mem", fwd_sel1_EX, 2'b01);

        // load-use: LW r7, consumer reads r7 as R2
        apply(5'd1, 5'd7, 1'b1, 1'b1, 5'd6, 5'd0, 5'd7, 2'b10, 1'b0, 1'b0);
        lit("lu_stall_en", {enable_PC, enable_IF}, 2'b00);
        lit("lu_stall_clr", {clear_IF, clear_RR}, 2'b01);
        apply(5'd1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("lu_ldstall", {enable_PC, clear_RR}, 2'b10);
        apply(5'd4, 5'd4, 1'b1, 1'b1, 5'd1, 5'd7, 5'd8, 2'b01, 1'b0, 1'b0);
        lit("lu_fwd_wb", fwd_sel2_EX, 2'b10);

        // load to r0 with r0 reader, then unused-source match
        apply(5'd0, 5'd3, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 2'b10, 1'b0, 1'b0);
        lit("r0_no_stall", {enable_PC, clear_RR}, 2'b10);
        apply(5'd9, 5'd1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 2'b10, 1'b0, 1'b0);
        lit("unused_no_stall", {enable_PC, clear_RR}, 2'b10);
        lit("unused_fwd", {fwd_sel1_EX[0], fwd_sel2_EX[0]}, 2'b00);

        // taken branch with a concurrent load-use hazard
        apply(5'd9, 5'd1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd9, 2'b10, 1'b1, 1'b0);
        lit("br_clear0", {clear_IF, clear_RR}, 2'b11);
        lit("br_en0", {enable_PC, enable_IF}, 2'b11);
        apply(5'd9, 5'd1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd9, 2'b10, 1'b0, 1'b0);
        lit("br_clear1", {clear_IF, clear_RR}, 2'b11);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("br_run", {clear_IF, enable_PC}, 2'b01);

        // mem_busy held three cycles during LDSTALL
        apply(5'd10, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd10, 2'b10, 1'b0, 1'b0);
        lit("busy_lu", {enable_PC, clear_RR}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            apply(5'd10, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
            lit("busy_freeze", {enable_PC, enable_MEM}, 2'b00);
        end
        apply(5'd10, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("busy_ldstall_done", {enable_PC, clear_RR}, 2'b10);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 5'd0, 5'd11, 2'b01, 1'b0, 1'b0);
        lit("busy_tracker_held", fwd_sel1_EX, 2'b10);

        // mem_busy extends FLUSH
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b1);
        lit("flush_busy", {clear_IF, enable_PC}, 2'b00);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("flush_resume", {clear_IF, clear_RR}, 2'b11);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("flush_end", {clear_IF, clear_RR}, 2'b00);

        // asynchronous reset in the middle of FLUSH
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 1'b0);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("pre_reset_flush", {clear_IF, clear_RR}, 2'b11);
        reset = 1'b0;
        #1;
        lit("async_reset_clr", {clear_IF, clear_RR}, 2'b00);
        lit("async_reset_en", {enable_PC, enable_RR}, 2'b11);
        @(posedge clk);
        #1 reset = 1'b1;
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
        lit("post_reset_run", {clear_IF, clear_RR}, 2'b00);
        apply(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd0, 2'b00, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
